// File: rtl/add_sub8_pkg.sv
// Shared constants for the add/sub datapath: operation encodings on ci
// and the default operand width.
package add_sub_pkg;

    localparam int  WIDTH_DEF = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic co;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/add_sub8_if.sv
// Operand/result bundle between an issuing master and the add_sub8 core.
interface add_sub8_if #(
    parameter int WIDTH = add_sub_pkg::WIDTH_DEF
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             co;
    logic [WIDTH-1:0] s;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, ci,
        input  out_valid, co, s, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, ci,
        output out_valid, co, s, ovf, zero
    );
endinterface

// File: rtl/add_sub8_full_adder.sv
// One-bit full adder cell used to build the ripple chain.
// Latency: combinational. Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/add_sub8.sv
// Two's-complement adder/subtractor (ci: 0 = add, 1 = subtract) with flags.
// Latency: 1 cycle, registered outputs. Backpressure: none, 1 op/cycle.
module add_sub8
    import add_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    add_sub8_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_s;
    flags_t           flags_nxt;
    flags_t           flags_q;
    logic [WIDTH-1:0] s_q;
    logic             out_valid_q;

    // Subtraction is a + ~b + 1: ci both inverts b and feeds the chain's carry-in.
    assign b_eff    = bus.b ^ {WIDTH{bus.ci}};
    assign carry[0] = bus.ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a    (bus.a[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .s    (sum_s[i]),
            .cout (carry[i+1])
        );
    end

    // Signed overflow: both operands agree in sign but the result does not.
    always_comb begin
        flags_nxt.co   = carry[WIDTH];
        flags_nxt.ovf  = (bus.a[MSB] == b_eff[MSB]) && (sum_s[MSB] != bus.a[MSB]);
        flags_nxt.zero = (sum_s == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s_q     <= sum_s;
                flags_q <= flags_nxt;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.co        = flags_q.co;
    assign bus.ovf       = flags_q.ovf;
    assign bus.zero      = flags_q.zero;
endmodule

// File: tb/tb_add_sub8.sv
// Self-checking bench for add_sub8 against an integer-arithmetic reference.
module tb_add_sub8;
    import add_sub_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    add_sub8_if #(.WIDTH(8)) bus ();

    add_sub8 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected {s, co, ovf, zero} from plain unsigned/signed arithmetic.
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic ci);
        int ua, ub, sa, sb, r, sr;
        logic [7:0] s;
        logic co, ovf;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (ci == OP_ADD) begin
            r  = ua + ub;
            co = (r >= 256);
            sr = sa + sb;
        end else begin
            r  = ua - ub;
            co = (ua >= ub);
            sr = sa - sb;
        end
        s   = 8'(r & 255);
        ovf = (sr > 127) || (sr < -128);
        return {s, co, ovf, (s == 8'h00)};
    endfunction

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic ci);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.ci       = ci;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
            tick();
            n_vec++;
            if ({bus.out_valid, bus.s, bus.co, bus.ovf, bus.zero} !== 12'h000) begin
                n_err++;
                $display("FAIL reset[%0d]: got v=%b s=%h co=%b ovf=%b z=%b, want all zero",
                         i, bus.out_valid, bus.s, bus.co, bus.ovf, bus.zero);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] ta [8] = '{8'h01, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h7F, 8'h80};
        logic [7:0] tb [8] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        logic       tc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] es [8] = '{8'h02, 8'h00, 8'h00, 8'hFE, 8'h01, 8'hFF, 8'h80, 8'h7F};
        logic       ec [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       eo [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ta[i], tb[i], tc[i]);
            tick();
            n_vec++;
            if ({bus.out_valid, bus.s, bus.co, bus.ovf, bus.zero} !==
                {1'b1, es[i], ec[i], eo[i], (es[i] == 8'h00)}) begin
                n_err++;
                $display("FAIL directed[%0d] %h%s%h: got v=%b s=%h co=%b ovf=%b z=%b, want v=1 s=%h co=%b ovf=%b z=%b",
                         i, ta[i], tc[i] ? "-" : "+", tb[i], bus.out_valid, bus.s, bus.co,
                         bus.ovf, bus.zero, es[i], ec[i], eo[i], (es[i] == 8'h00));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a, b;
        logic        ci;
        logic [10:0] exp;
        for (int i = 0; i < 200; i++) begin
            a  = 8'($urandom);
            b  = (i % 8 == 0) ? a : 8'($urandom);
            ci = 1'($urandom);
            exp = model(a, b, ci);
            drive(1'b1, a, b, ci);
            tick();
            n_vec++;
            if ({bus.out_valid, bus.s, bus.co, bus.ovf, bus.zero} !== {1'b1, exp}) begin
                n_err++;
                $display("FAIL b2b[%0d] %h%s%h: got v=%b s=%h co=%b ovf=%b z=%b, want s=%h co=%b ovf=%b z=%b",
                         i, a, ci ? "-" : "+", b, bus.out_valid, bus.s, bus.co, bus.ovf,
                         bus.zero, exp[10:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_gap();
        logic [7:0]  a, b;
        logic        ci;
        logic [10:0] held;
        for (int i = 0; i < 10; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            ci = 1'($urandom);
            held = model(a, b, ci);
            drive(1'b1, a, b, ci);
            tick();
            for (int g = 0; g < 1 + (i % 3); g++) begin
                drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
                tick();
                n_vec++;
                if ({bus.out_valid, bus.s, bus.co, bus.ovf, bus.zero} !== {1'b0, held}) begin
                    n_err++;
                    $display("FAIL gap[%0d.%0d]: got v=%b s=%h co=%b ovf=%b z=%b, want v=0 held s=%h co=%b ovf=%b z=%b",
                             i, g, bus.out_valid, bus.s, bus.co, bus.ovf, bus.zero,
                             held[10:3], held[2], held[1], held[0]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 8'h7F, 8'h01, OP_ADD);
        tick();
        rst = 1'b1;
        drive(1'b1, 8'h12, 8'h34, OP_ADD);
        tick();
        n_vec++;
        if ({bus.out_valid, bus.s, bus.co, bus.ovf, bus.zero} !== 12'h000) begin
            n_err++;
            $display("FAIL rst_mid: got v=%b s=%h co=%b ovf=%b z=%b, want all zero",
                     bus.out_valid, bus.s, bus.co, bus.ovf, bus.zero);
        end
        rst = 1'b0;
        drive(1'b0, 8'h55, 8'h55, OP_SUB);
        tick();
        n_vec++;
        if ({bus.out_valid, bus.s, bus.co, bus.ovf, bus.zero} !== 12'h000) begin
            n_err++;
            $display("FAIL rst_after: got v=%b s=%h co=%b ovf=%b z=%b, want all zero",
                     bus.out_valid, bus.s, bus.co, bus.ovf, bus.zero);
        end
        drive(1'b1, 8'h55, 8'h55, OP_SUB);
        tick();
        n_vec++;
        if ({bus.out_valid, bus.s, bus.co, bus.ovf, bus.zero} !== {1'b1, 8'h00, 3'b101}) begin
            n_err++;
            $display("FAIL rst_resume: got v=%b s=%h co=%b ovf=%b z=%b, want v=1 s=00 co=1 ovf=0 z=1",
                     bus.out_valid, bus.s, bus.co, bus.ovf, bus.zero);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, OP_ADD);
        #2;
        test_reset();
        test_directed();
        test_back_to_back();
        test_gap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/add_sub8.md
Name: add_sub8

Overview:
- 8-bit two's-complement adder/subtractor with registered outputs, for datapath/ALU use.
- Input `ci` is the operation select: 0 = add (a+b), 1 = subtract (a-b).
- `co` is the carry-out; in subtract mode it is the inverted borrow.
- One clock; synchronous, active-high reset; result appears one cycle after inputs are sampled.

Parameters:
- WIDTH, 8, operand and result width in bits. The test plan values assume 8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands and op valid this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  op select: 0 = add, 1 = subtract
- out_valid  out  1  s/co/ovf/zero hold a new result
- co  out  1  carry out of the MSB (subtract: 1 = no borrow)
- s  out  WIDTH  result, modulo 2^WIDTH
- ovf  out  1  signed two's-complement overflow
- zero  out  1  s == 0

Behaviour:
- Core: `sum = a + (b XOR {WIDTH{ci}}) + ci`, computed as a WIDTH+1-bit result.
  - s = sum[WIDTH-1:0]
  - co = sum[WIDTH]
- Add (ci=0): s = (a+b) mod 2^WIDTH; co = 1 iff a+b >= 2^WIDTH.
- Subtract (ci=1): s = (a-b) mod 2^WIDTH; co = 1 iff a >= b (unsigned), so co = 0 signals a borrow.
- ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]), where b_eff = b XOR {WIDTH{ci}}.
- zero = (s == 0).
- Timing: on a clk rising edge with in_valid=1, the result registers load. out_valid = 1 in the following cycle, with the registered values.
- Latency is exactly 1 cycle. Throughput is 1 op/cycle, with no back-pressure.
- in_valid=0 at an edge: out_valid drops to 0 next cycle; s/co/ovf/zero hold their previous values.
- Reset (rst=1 at an edge, takes priority over in_valid):
  - out_valid=0, s=0, co=0, ovf=0, zero=0.
  - Applies mid-stream: an op sampled in the same cycle as rst is discarded.
- Wrap-around is modulo 2^WIDTH with no saturation.
- X/Z on a, b or ci with in_valid=1 propagates to the outputs; no X-masking.
- There is no combinational path from inputs to outputs.

Decomposition:
- Shared package add_sub_pkg:
  - constants OP_ADD = 1'b0 and OP_SUB = 1'b1 for `ci`
  - default WIDTH = 8
- One sub-module `full_adder` (1-bit: a, b, cin -> s, cout), instantiated WIDTH times in a ripple chain via generate.
  - The B-inversion XOR and the MSB carry-in/carry-out taps used for ovf sit in add_sub8.
- Output register stage lives in add_sub8.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> out_valid=0, s=00000000, co=0, ovf=0, zero=0.
- a=00000001, b=00000001, in_valid=1:
  - ci=0 -> next cycle s=00000010, co=0
  - ci=1 -> s=00000000, co=1, zero=1
- a=11111111, b=00000001:
  - ci=0 -> s=00000000, co=1, zero=1, ovf=0
  - ci=1 -> s=11111110, co=1
- a=00000000, b=00000001:
  - ci=0 -> s=00000001, co=0
  - ci=1 -> s=11111111, co=0 (borrow)
- Overflow:
  - a=01111111, b=00000001, ci=0 -> s=10000000, ovf=1
  - a=10000000, b=00000001, ci=1 -> s=01111111, ovf=1
- Back-to-back ops on consecutive cycles -> each result appears exactly 1 cycle later.
- in_valid=0 gap -> out_valid=0 and s holds.
- rst asserted while in_valid=1 -> that op is dropped and outputs clear.
